// File: rtl/seq_alu.sv
// seq_alu: handshaked execute-stage ALU. Simple ops complete in one cycle;
// MUL (shift-add) and DIVU/REMU (restoring division) iterate WIDTH cycles.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_NOT  = 4'd2,  OP_AND  = 4'd3,
        OP_OR   = 4'd4,  OP_XOR  = 4'd5,  OP_SLT  = 4'd6,  OP_EQ   = 4'd7,
        OP_SLTU = 4'd8,  OP_SLL  = 4'd9,  OP_SRL  = 4'd10, OP_SRA  = 4'd11,
        OP_MUL  = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14, OP_RSVD = 4'd15
    } op_e;

    state_e           state, state_nx;
    op_e              op_in, op_q;
    logic             iterative;
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf;
    logic [SHW-1:0]   shamt;

    // Iteration registers: x_q = multiplicand / dividend-quotient,
    // y_q = multiplier / divisor, acc_q = product / partial remainder.
    logic [WIDTH-1:0] x_q, y_q, acc_q;
    logic [SHW-1:0]   cnt_q;

    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub, rem_nx, quo_nx;
    logic             div_ge;

    assign op_in     = op_e'(op);
    assign iterative = (op_in == OP_MUL) || (op_in == OP_DIVU) || (op_in == OP_REMU);
    assign sum       = a + b;
    assign diff      = a - b;
    assign shamt     = b[SHW-1:0];

    // Single-cycle ALU result and signed overflow for the presented operands
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  alu_res = ~a;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_EQ:   alu_res = WIDTH'(a == b);
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // One iteration step of shift-add multiply and restoring division.
    // The remainder never exceeds WIDTH bits once restored (it is < divisor,
    // or a prefix of the dividend when the divisor is zero), so only the
    // shifted trial value needs the extra bit.
    always_comb begin
        mul_sum = acc_q + (y_q[0] ? x_q : '0);
        rem_sh  = {acc_q, x_q[WIDTH-1]};
        div_ge  = rem_sh >= {1'b0, y_q};
        rem_sub = rem_sh[WIDTH-1:0] - y_q;
        rem_nx  = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
        quo_nx  = {x_q[WIDTH-2:0], div_ge};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (in_valid) state_nx = iterative ? S_BUSY : S_DONE;
                S_BUSY:  if (cnt_q == '0) state_nx = S_DONE;
                S_DONE:  if (out_ready) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == S_IDLE) && !rst;
        out_valid = (state == S_DONE);
    end

    // Datapath: operand capture, iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            overflow <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op_in;
                        if (iterative) begin
                            x_q   <= a;
                            y_q   <= b;
                            acc_q <= '0;
                            cnt_q <= SHW'(WIDTH - 1);
                        end else begin
                            result   <= alu_res;
                            overflow <= alu_ovf;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - SHW'(1);
                    if (op_q == OP_MUL) begin
                        acc_q <= mul_sum;
                        x_q   <= x_q << 1;
                        y_q   <= y_q >> 1;
                    end else begin
                        acc_q <= rem_nx;
                        x_q   <= quo_nx;
                    end
                    if (cnt_q == '0) begin
                        overflow <= 1'b0;
                        if (op_q == OP_MUL)       result <= mul_sum;
                        else if (op_q == OP_DIVU) result <= quo_nx;
                        else                      result <= rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed, table-driven bench for seq_alu at WIDTH=32.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          lat;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one op, measure accept-to-out_valid latency, check the result,
    // then hand it off and confirm the block is ready again.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic eo, input int el, input string nm);
        int   lat;
        logic seen;
        logic busy_rdy;
        @(negedge clk);
        chk({nm, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; seen = 1'b0; busy_rdy = 1'b0;
        while (lat < 40 && !seen) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
            else if (in_ready) busy_rdy = 1'b1;
        end
        chk({nm, " latency"}, lat, el);
        chk({nm, " in_ready while busy"}, {31'd0, busy_rdy}, 32'd0);
        chk({nm, " result"}, result, er);
        chk({nm, " overflow"}, {31'd0, overflow}, {31'd0, eo});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({nm, " in_ready after handoff"}, {31'd0, in_ready}, 32'd1);
        chk({nm, " out_valid after handoff"}, {31'd0, out_valid}, 32'd0);
    endtask

    vec_t vecs[24];

    initial begin
        int   flushed_seen;
        logic stall_bad;

        vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1,  "ADD ovf"};
        vecs[1]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1,  "SUB ovf"};
        vecs[2]  = '{4'd0,  32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1,  "ADD"};
        vecs[3]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1,  "SUB neg"};
        vecs[4]  = '{4'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1,  "ADD negovf"};
        vecs[5]  = '{4'd2,  32'h0F0F0F0F, 32'h12345678, 32'hF0F0F0F0, 1'b0, 1,  "NOT"};
        vecs[6]  = '{4'd3,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1,  "AND"};
        vecs[7]  = '{4'd4,  32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1'b0, 1,  "OR"};
        vecs[8]  = '{4'd5,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1,  "XOR"};
        vecs[9]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1,  "SLT"};
        vecs[10] = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1,  "SLTU"};
        vecs[11] = '{4'd7,  32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1,  "EQ ne"};
        vecs[12] = '{4'd11, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1,  "SRA"};
        vecs[13] = '{4'd10, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1,  "SRL"};
        vecs[14] = '{4'd9,  32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1,  "SLL 31"};
        vecs[15] = '{4'd15, 32'h00000123, 32'h00000456, 32'h00000000, 1'b0, 1,  "RSVD"};
        vecs[16] = '{4'd12, 32'd12345,    32'd6789,     32'h04FED79D, 1'b0, 33, "MUL"};
        vecs[17] = '{4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33, "MUL -1"};
        vecs[18] = '{4'd13, 32'd100,      32'd7,        32'd14,       1'b0, 33, "DIVU"};
        vecs[19] = '{4'd14, 32'd100,      32'd7,        32'd2,        1'b0, 33, "REMU"};
        vecs[20] = '{4'd13, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33, "DIVU by0"};
        vecs[21] = '{4'd14, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 33, "REMU by0"};
        vecs[22] = '{4'd13, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 33, "DIVU max"};
        vecs[23] = '{4'd14, 32'hFFFFFFFF, 32'd10,       32'd5,        1'b0, 33, "REMU max"};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = '0; b = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("in_ready after reset release", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].lat, vecs[i].nm);

        // Backpressure: ADD 3+4 held in DONE for 5 cycles with a stray in_valid
        @(negedge clk);
        in_valid = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1 op = 4'd1; a = 32'd100; b = 32'd1;
        stall_bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (result !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0) stall_bad = 1'b1;
        end
        chk("stall result/valid/ready held", {31'd0, stall_bad}, 32'd0);
        chk("stall result", result, 32'd7);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall in_ready after handoff", {31'd0, in_ready}, 32'd1);
        chk("stall out_valid after handoff", {31'd0, out_valid}, 32'd0);
        chk("stall ignored op left result", result, 32'd7);

        // flush together with out_ready in DONE: flush wins, result held
        in_valid = 1'b1; op = 4'd0; a = 32'd20; b = 32'd22;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("flush-done out_valid before", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; out_ready = 1'b0;
        chk("flush-done out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush-done in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush-done result kept", result, 32'd42);

        // flush on the 10th BUSY cycle of a MUL
        @(negedge clk);
        in_valid = 1'b1; op = 4'd12; a = 32'd12345; b = 32'd6789;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("mul in_ready during busy", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush-mul in_ready next", {31'd0, in_ready}, 32'd1);
        flushed_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) flushed_seen++;
        end
        chk("flush-mul never valid", flushed_seen, 0);
        chk("flush-mul result kept", result, 32'd42);
        run_op(4'd7, 32'd5, 32'd5, 32'd1, 1'b0, 1, "EQ after flush");

        // Async reset pulse mid-DIVU
        @(negedge clk);
        in_valid = 1'b1; op = 4'd13; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst result", result, 32'd0);
        chk("async rst overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready after rst pulse", {31'd0, in_ready}, 32'd1);
        flushed_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) flushed_seen++;
        end
        chk("discarded divu never valid", flushed_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
